// File: rtl/cache_arbiter_if.sv
// ---------------------------------------------------------------------------
// cache_arbiter_if
// Bus bundle between two requesters, the arbiter and a single cache port.
//   m0_* / m1_* : requester side (req/wr/addr/wdata in, addr_ok/data_ok/rdata out)
//   c_*         : cache side (req/wr/addr/wdata out, addr_ok/data_ok/rdata in)
// Modports:
//   slave  : the arbiter's view
//   master : the environment's view (requesters and cache model)
// ---------------------------------------------------------------------------
interface cache_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              m0_req;
    logic              m0_wr;
    logic [ADDR_W-1:0] m0_addr;
    logic [DATA_W-1:0] m0_wdata;
    logic              m0_addr_ok;
    logic              m0_data_ok;
    logic [DATA_W-1:0] m0_rdata;

    logic              m1_req;
    logic              m1_wr;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_wdata;
    logic              m1_addr_ok;
    logic              m1_data_ok;
    logic [DATA_W-1:0] m1_rdata;

    logic              c_req;
    logic              c_wr;
    logic [ADDR_W-1:0] c_addr;
    logic [DATA_W-1:0] c_wdata;
    logic              c_addr_ok;
    logic              c_data_ok;
    logic [DATA_W-1:0] c_rdata;

    modport slave (
        input  m0_req, m0_wr, m0_addr, m0_wdata,
        input  m1_req, m1_wr, m1_addr, m1_wdata,
        input  c_addr_ok, c_data_ok, c_rdata,
        output m0_addr_ok, m0_data_ok, m0_rdata,
        output m1_addr_ok, m1_data_ok, m1_rdata,
        output c_req, c_wr, c_addr, c_wdata
    );

    modport master (
        output m0_req, m0_wr, m0_addr, m0_wdata,
        output m1_req, m1_wr, m1_addr, m1_wdata,
        output c_addr_ok, c_data_ok, c_rdata,
        input  m0_addr_ok, m0_data_ok, m0_rdata,
        input  m1_addr_ok, m1_data_ok, m1_rdata,
        input  c_req, c_wr, c_addr, c_wdata
    );
endinterface

// File: rtl/cache_arbiter.sv
// ---------------------------------------------------------------------------
// cache_arbiter
// Two-requester round-robin arbiter in front of one cache port, one access
// outstanding at a time (IDLE -> ADDR -> WAIT -> IDLE).
// Ports:
//   clk          : clock, rising edge
//   resetn       : asynchronous active-low reset
//   bus          : cache_arbiter_if.slave (requester and cache handshakes)
//   err_timeout  : sticky flag, WAIT lasted more than TIMEOUT cycles
// ---------------------------------------------------------------------------
module cache_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 1023
) (
    input  logic            clk,
    input  logic            resetn,
    cache_arbiter_if.slave  bus,
    output logic            err_timeout
);
    localparam int               CNT_W    = $clog2(TIMEOUT + 2);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t           state;
    logic             last_grant;
    logic             gnt;
    logic [CNT_W-1:0] wait_cnt;

    logic             win_vld;
    logic             win_id;

    // Acceptance stage: addr_ok must appear in the cycle the request is
    // taken, so the grant decision is decoded from state and requests.
    // Gating with resetn keeps addr_ok low while reset is asserted.
    always_comb begin
        win_vld = resetn && (state == IDLE) && (bus.m0_req || bus.m1_req);
        if (bus.m0_req && bus.m1_req) begin
            win_id = ~last_grant;
        end else begin
            win_id = bus.m1_req;
        end
    end

    assign bus.m0_addr_ok = win_vld && !win_id;
    assign bus.m1_addr_ok = win_vld &&  win_id;

    // Control and response stage
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state          <= IDLE;
            last_grant     <= 1'b1;
            gnt            <= 1'b0;
            wait_cnt       <= '0;
            err_timeout    <= 1'b0;
            bus.c_req      <= 1'b0;
            bus.c_wr       <= 1'b0;
            bus.c_addr     <= {ADDR_W{1'b0}};
            bus.c_wdata    <= {DATA_W{1'b0}};
            bus.m0_data_ok <= 1'b0;
            bus.m1_data_ok <= 1'b0;
            bus.m0_rdata   <= {DATA_W{1'b0}};
            bus.m1_rdata   <= {DATA_W{1'b0}};
        end else begin
            bus.m0_data_ok <= 1'b0;
            bus.m1_data_ok <= 1'b0;
            case (state)
                IDLE: begin
                    if (win_vld) begin
                        gnt         <= win_id;
                        last_grant  <= win_id;
                        bus.c_wr    <= win_id ? bus.m1_wr    : bus.m0_wr;
                        bus.c_addr  <= win_id ? bus.m1_addr  : bus.m0_addr;
                        bus.c_wdata <= win_id ? bus.m1_wdata : bus.m0_wdata;
                        bus.c_req   <= 1'b1;
                        state       <= ADDR;
                    end
                end
                ADDR: begin
                    if (bus.c_addr_ok) begin
                        bus.c_req <= 1'b0;
                        wait_cnt  <= '0;
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    // Counter saturates so the flag logic never wraps; the
                    // access is still allowed to complete after a timeout.
                    if (wait_cnt != CNT_SAT) begin
                        wait_cnt <= wait_cnt + CNT_ONE;
                    end
                    if (wait_cnt == CNT_LAST) begin
                        err_timeout <= 1'b1;
                    end
                    if (bus.c_data_ok) begin
                        // Writes also load rdata; its content is don't-care.
                        if (gnt) begin
                            bus.m1_rdata   <= bus.c_rdata;
                            bus.m1_data_ok <= 1'b1;
                        end else begin
                            bus.m0_rdata   <= bus.c_rdata;
                            bus.m0_data_ok <= 1'b1;
                        end
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_cache_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cache_arbiter
// Randomized transaction-level bench: plays both requesters and the cache,
// predicts the winner, cache fields, read-back data and timeout flag from
// the arbitration rules, and compares at the falling edge.
// ---------------------------------------------------------------------------
module tb_cache_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic resetn;
    logic err_timeout;

    always #5 clk = ~clk;

    cache_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    cache_arbiter #(
        .ADDR_W (AW),
        .DATA_W (DW),
        .TIMEOUT(TO)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .bus        (bus),
        .err_timeout(err_timeout)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Requester state: pending request and its fields (held until accepted)
    logic          pend    [2];
    logic          p_wr    [2];
    logic [AW-1:0] p_addr  [2];
    logic [DW-1:0] p_wdata [2];

    // Reference model state
    logic          lg;          // requester granted most recently
    logic          err_m;       // expected sticky timeout flag
    logic          dok_vld;     // a data_ok pulse is due in this cycle
    logic          dok_id;
    logic [DW-1:0] rd_m [2];    // expected rdata per requester

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic coin();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic new_req(input int id);
        pend[id]    = 1'b1;
        p_wr[id]    = coin();
        p_addr[id]  = $urandom;
        p_wdata[id] = $urandom;
    endtask

    task automatic drive_reqs();
        bus.m0_req   = pend[0];
        bus.m0_wr    = p_wr[0];
        bus.m0_addr  = p_addr[0];
        bus.m0_wdata = p_wdata[0];
        bus.m1_req   = pend[1];
        bus.m1_wr    = p_wr[1];
        bus.m1_addr  = p_addr[1];
        bus.m1_wdata = p_wdata[1];
    endtask

    task automatic model_reset();
        lg      = 1'b1;
        err_m   = 1'b0;
        dok_vld = 1'b0;
        dok_id  = 1'b0;
        rd_m[0] = '0;
        rd_m[1] = '0;
    endtask

    task automatic check_reset();
        chk("rst_creq",   64'(bus.c_req),      64'(0));
        chk("rst_cwr",    64'(bus.c_wr),       64'(0));
        chk("rst_caddr",  64'(bus.c_addr),     64'(0));
        chk("rst_cwdata", 64'(bus.c_wdata),    64'(0));
        chk("rst_aok",    64'({bus.m1_addr_ok, bus.m0_addr_ok}), 64'(0));
        chk("rst_dok",    64'({bus.m1_data_ok, bus.m0_data_ok}), 64'(0));
        chk("rst_rdata0", 64'(bus.m0_rdata),   64'(0));
        chk("rst_rdata1", 64'(bus.m1_rdata),   64'(0));
        chk("rst_err",    64'(err_timeout),    64'(0));
    endtask

    // One access. Entered at posedge+1 of a cycle in which the arbiter is
    // idle; returns at posedge+1 of the next idle cycle. sa/sd are cache
    // stall cycles before addr_ok/data_ok; rst_k >= 0 resets in that WAIT cycle.
    task automatic txn(input int sa, input int sd, input int rst_k);
        logic          w;
        logic          cw;
        logic [AW-1:0] ca;
        logic [DW-1:0] cd;
        logic [DW-1:0] rd;

        if (!pend[0] && !pend[1]) new_req(int'(coin()));
        drive_reqs();
        bus.c_addr_ok = coin();
        bus.c_data_ok = coin();
        bus.c_rdata   = $urandom;
        w = (pend[0] && pend[1]) ? ~lg : pend[1];
        #4;
        chk("dok0",      64'(bus.m0_data_ok), 64'(dok_vld && !dok_id));
        chk("dok1",      64'(bus.m1_data_ok), 64'(dok_vld &&  dok_id));
        chk("rdata0",    64'(bus.m0_rdata),   64'(rd_m[0]));
        chk("rdata1",    64'(bus.m1_rdata),   64'(rd_m[1]));
        chk("aok0",      64'(bus.m0_addr_ok), 64'(!w));
        chk("aok1",      64'(bus.m1_addr_ok), 64'(w));
        chk("creq_idle", 64'(bus.c_req),      64'(0));
        chk("err_idle",  64'(err_timeout),    64'(err_m));
        dok_vld = 1'b0;
        lg      = w;
        cw      = p_wr[w];
        ca      = p_addr[w];
        cd      = p_wdata[w];
        pend[w] = 1'b0;

        @(posedge clk); #1;
        // New requests raised now must wait until the arbiter is idle again.
        if (coin()) new_req(int'(w));
        drive_reqs();
        for (int k = 0; k <= sa; k++) begin
            if (k == 1 && !pend[!w] && coin()) new_req(int'(!w));
            drive_reqs();
            bus.c_addr_ok = (k == sa);
            bus.c_data_ok = coin();
            bus.c_rdata   = $urandom;
            #4;
            chk("creq",     64'(bus.c_req),   64'(1));
            chk("cwr",      64'(bus.c_wr),    64'(cw));
            chk("caddr",    64'(bus.c_addr),  64'(ca));
            chk("cwdata",   64'(bus.c_wdata), 64'(cd));
            chk("aok_addr", 64'({bus.m1_addr_ok, bus.m0_addr_ok}), 64'(0));
            chk("dok_addr", 64'({bus.m1_data_ok, bus.m0_data_ok}), 64'(0));
            chk("err_addr", 64'(err_timeout), 64'(err_m));
            @(posedge clk); #1;
        end

        rd = '0;
        for (int k = 0; k <= sd; k++) begin
            if (k == rst_k) begin
                if (!pend[0]) new_req(0);
                if (!pend[1]) new_req(1);
                drive_reqs();
                bus.c_data_ok = 1'b1;
                resetn = 1'b0;
                #1;
                check_reset();
                @(posedge clk); #1;
                check_reset();
                @(posedge clk); #1;
                resetn = 1'b1;
                model_reset();
                return;
            end
            bus.c_addr_ok = coin();
            bus.c_data_ok = (k == sd);
            rd            = $urandom;
            bus.c_rdata   = rd;
            #4;
            chk("creq_wait", 64'(bus.c_req), 64'(0));
            chk("aok_wait",  64'({bus.m1_addr_ok, bus.m0_addr_ok}), 64'(0));
            chk("dok_wait",  64'({bus.m1_data_ok, bus.m0_data_ok}), 64'(0));
            chk("err_wait",  64'(err_timeout), 64'(err_m || (k >= TO + 1)));
            @(posedge clk); #1;
        end
        if (sd + 1 >= TO + 1) err_m = 1'b1;
        rd_m[w] = rd;
        dok_vld = 1'b1;
        dok_id  = w;
    endtask

    initial begin
        resetn = 1'b1;
        bus.c_addr_ok = 1'b0;
        bus.c_data_ok = 1'b0;
        bus.c_rdata   = '0;
        for (int i = 0; i < 2; i++) begin
            pend[i] = 1'b0; p_wr[i] = 1'b0; p_addr[i] = '0; p_wdata[i] = '0;
        end
        model_reset();
        drive_reqs();
        #1 resetn = 1'b0;
        new_req(0);
        new_req(1);
        drive_reqs();
        #1 check_reset();
        repeat (2) @(posedge clk);
        #1 check_reset();
        resetn = 1'b1;

        // Tie after reset: m0 first, then strict alternation
        for (int i = 0; i < 4; i++) begin
            if (!pend[0]) new_req(0);
            if (!pend[1]) new_req(1);
            txn(0, 0, -1);
        end

        // Cache address stall of five cycles
        txn(5, 0, -1);

        // Random traffic with random cache latencies
        for (int i = 0; i < 40; i++) begin
            txn(int'($urandom_range(0, 5)), int'($urandom_range(0, 3)), -1);
        end

        // Data stall past the timeout; flag must remain set afterwards
        txn(2, 12, -1);
        for (int i = 0; i < 4; i++) begin
            txn(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), -1);
        end

        // Reset in the middle of WAIT, then more traffic
        txn(1, 6, 3);
        for (int i = 0; i < 10; i++) begin
            txn(int'($urandom_range(0, 4)), int'($urandom_range(0, 9)), -1);
        end
        txn(0, 0, -1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
